// File: rtl/bomberman_debug_slave_sysclk_mc.sv
// Debug slave, system-clock side: synchronizes JTAG update strobes,
// decodes each DR update and queues commands in a fall-through FIFO.
module bomberman_debug_slave_sysclk_mc #(
    parameter int DATA_W      = 38,
    parameter int NUM_BRK     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CMD_DEPTH   = 4,
    localparam int CH_W = (NUM_BRK > 1) ? $clog2(NUM_BRK) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs_uir,
    input  logic              vs_udr,
    input  logic [1:0]        ir_in,
    input  logic [DATA_W-1:0] sr,
    input  logic              cmd_ready,
    input  logic              err_clr,
    output logic              cmd_valid,
    output logic [1:0]        cmd_target,
    output logic [1:0]        cmd_op,
    output logic              cmd_take,
    output logic [CH_W-1:0]   cmd_chan,
    output logic [DATA_W-1:0] jdo,
    output logic              cmd_overflow,
    output logic              cmd_err
);

    localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int EW = 2 + 2 + 1 + CH_W + DATA_W;

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(CMD_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CH_W:0] NB_C    = (CH_W + 1)'(NUM_BRK);

    localparam logic [1:0] IR_OCIMEM = 2'd0;
    localparam logic [1:0] IR_TRACE  = 2'd1;
    localparam logic [1:0] IR_BREAK  = 2'd2;
    localparam logic [1:0] IR_RSVD   = 2'd3;

    // Synchronizer chains; fill_q marks when the chain output is real data
    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   uir_prev_q;
    logic                   udr_prev_q;
    logic                   uir_arm_q;
    logic                   udr_arm_q;
    logic                   uir_s;
    logic                   udr_s;
    logic                   sync_ok;
    logic                   uir_p;
    logic                   udr_p;

    logic [1:0]             ir_q;

    logic [1:0]             dec_op;
    logic                   dec_take;
    logic [CH_W-1:0]        dec_chan;
    logic                   dec_bad;
    logic                   wr_req;
    logic [EW-1:0]          wr_entry;

    logic [EW-1:0]          mem_q [CMD_DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW-1:0]          rd_ptr_d;
    logic [AW:0]            cnt_q;
    logic [AW:0]            cnt_d;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   ovf_set;
    logic [EW-1:0]          head;

    logic                   ovf_q;
    logic                   ovf_d;
    logic                   err_q;
    logic                   err_d;

    // Shift the asynchronous levels through the synchronizer chains
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            fill_q     <= '0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign uir_s   = uir_sync_q[SYNC_STAGES-1];
    assign udr_s   = udr_sync_q[SYNC_STAGES-1];
    assign sync_ok = fill_q[SYNC_STAGES-1];

    // Edge history; a line arms only once it has really been seen low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_prev_q <= 1'b0;
            udr_prev_q <= 1'b0;
            uir_arm_q  <= 1'b0;
            udr_arm_q  <= 1'b0;
        end else begin
            uir_prev_q <= uir_s;
            udr_prev_q <= udr_s;
            if (sync_ok && !uir_s) begin
                uir_arm_q <= 1'b1;
            end
            if (sync_ok && !udr_s) begin
                udr_arm_q <= 1'b1;
            end
        end
    end

    assign uir_p = uir_arm_q && uir_s && !uir_prev_q;
    assign udr_p = udr_arm_q && udr_s && !udr_prev_q;

    // Instruction register; a coincident DR update still sees the old value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= IR_OCIMEM;
        end else if (uir_p) begin
            ir_q <= ir_in;
        end
    end

    // Decode the DR snapshot against the current instruction
    always_comb begin
        dec_op   = sr[DATA_W-1 -: 2];
        dec_take = (dec_op != 2'd0);
        dec_chan = '0;
        dec_bad  = 1'b0;
        wr_req   = 1'b0;
        if (udr_p) begin
            unique case (ir_q)
                IR_OCIMEM: wr_req = 1'b1;
                IR_TRACE: begin
                    dec_take = 1'b1;
                    wr_req   = 1'b1;
                end
                IR_BREAK: begin
                    dec_chan = sr[DATA_W-3 -: CH_W];
                    if ({1'b0, dec_chan} >= NB_C) begin
                        dec_bad = 1'b1;
                    end else begin
                        wr_req = 1'b1;
                    end
                end
                IR_RSVD: wr_req = 1'b0;
                default: wr_req = 1'b0;
            endcase
        end
        wr_entry = {ir_q, dec_op, dec_take, dec_chan, sr};
    end

    assign full      = (cnt_q == DEPTH_C);
    assign cmd_valid = (cnt_q != '0);
    assign pop       = cmd_valid && cmd_ready;
    assign push      = wr_req && (!full || pop);
    assign ovf_set   = wr_req && full && !pop;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents are only visible while occupied
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head = cmd_valid ? mem_q[rd_ptr_q] : '0;

    assign jdo        = head[DATA_W-1:0];
    assign cmd_chan   = head[DATA_W +: CH_W];
    assign cmd_take   = head[DATA_W+CH_W];
    assign cmd_op     = head[DATA_W+CH_W+1 +: 2];
    assign cmd_target = head[DATA_W+CH_W+3 +: 2];

    // Sticky flags: a set in the same cycle beats a clear
    always_comb begin
        ovf_d = ovf_q;
        err_d = err_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            err_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end
        if (dec_bad) begin
            err_d = 1'b1;
        end
    end

    // Sticky flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign cmd_overflow = ovf_q;
    assign cmd_err      = err_q;

endmodule

// File: doc/bomberman_debug_slave_sysclk_mc.md
BOMBERMAN_DEBUG_SLAVE_SYSCLK_MC -- requirements
Module: bomberman_debug_slave_sysclk_mc

Interface
Parameters:
REQ-001 SHALL have parameter DATA_W, default 38, meaning width of the debug data word; legal values are at least 38.
REQ-002 SHALL have parameter NUM_BRK, default 4, meaning number of breakpoint channels; legal values 1..16; CH_W = max(1, clog2(NUM_BRK)).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for the update strobes; legal values 2..4.
REQ-004 SHALL have parameter CMD_DEPTH, default 4, meaning command FIFO depth; must be a power of 2, at least 2.
Ports (one clock; reset is asynchronous and active-low):
REQ-005 SHALL have port clk, input, 1 bit: system clock, all logic rising-edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port vs_uir, input, 1 bit: JTAG-domain update-IR level, asynchronous to clk.
REQ-008 SHALL have port vs_udr, input, 1 bit: JTAG-domain update-DR level, asynchronous to clk.
REQ-009 SHALL have port ir_in, input, 2 bits: instruction; 0 OCIMEM, 1 TRACECTRL, 2 BREAK, 3 reserved. Stable while vs_uir is high.
REQ-010 SHALL have port sr, input, DATA_W bits: shift-register snapshot; stable while vs_udr is high.
REQ-011 SHALL have port cmd_ready, input, 1 bit: consumer accepts the head entry.
REQ-012 SHALL have port err_clr, input, 1 bit: clears the sticky flags.
REQ-013 SHALL have port cmd_valid, output, 1 bit: FIFO non-empty.
REQ-014 SHALL have port cmd_target, output, 2 bits: registered IR of the head entry.
REQ-015 SHALL have port cmd_op, output, 2 bits: the head entry's jdo[DATA_W-1:DATA_W-2].
REQ-016 SHALL have port cmd_take, output, 1 bit: action (1) versus no-action (0).
REQ-017 SHALL have port cmd_chan, output, CH_W bits: breakpoint channel; 0 for non-BREAK entries.
REQ-018 SHALL have port jdo, output, DATA_W bits: the head entry's captured sr.
REQ-019 SHALL have port cmd_overflow, output, 1 bit: sticky, set when an entry is dropped because the FIFO is full.
REQ-020 SHALL have port cmd_err, output, 1 bit: sticky, set on an illegal channel.

Function
REQ-021 SHALL synchronize each of vs_uir and vs_udr through SYNC_STAGES flops, then detect rising edges into one-cycle pulses uir_p and udr_p.
REQ-022 SHALL suppress edge pulses on each line until that synchronized line has been observed low at least once after reset, so a level held high through reset produces no pulse.
REQ-023 SHALL load ir_in into ir_reg on uir_p.
REQ-024 SHALL make udr_p use the ir_reg value held before the current edge when uir_p and udr_p coincide; the new IR applies only from the next udr_p.
REQ-025 SHALL decode each udr_p at the same edge as follows:
- op = sr[DATA_W-1:DATA_W-2].
- take = (op != 0), except TRACECTRL, where take = 1.
- chan = sr[DATA_W-3 -: CH_W] for BREAK, otherwise 0.
REQ-026 SHALL handle exceptional decodes as follows:
- ir_reg == 3: discard, with no flag.
- BREAK with chan >= NUM_BRK: discard and set cmd_err.
REQ-027 SHALL otherwise write {target, op, take, chan, sr} into the FIFO at that edge.
REQ-028 SHALL give a latency from the first clk edge sampling vs_udr high to cmd_valid high of exactly SYNC_STAGES+1 edges, when the FIFO is empty.
REQ-029 SHALL drive the outputs from the FIFO head, first-word fall-through, and SHALL pop on (cmd_valid && cmd_ready).
REQ-030 SHALL ignore cmd_ready while the FIFO is empty.
REQ-031 SHALL keep the outputs stable while cmd_valid && !cmd_ready.
REQ-032 SHALL, when the FIFO is full with no pop at the same edge, drop the write, leave contents unchanged and set cmd_overflow.
REQ-033 SHALL, when the FIFO is full and a write and pop occur at the same edge, accept the write with no overflow.
REQ-034 SHALL wrap pointers modulo CMD_DEPTH; occupancy SHALL be held in a clog2(CMD_DEPTH)+1-bit counter.
REQ-035 SHALL clear both sticky flags on err_clr; a set event in the same cycle SHALL win.

Reset
REQ-036 SHALL, on reset_n low, asynchronously clear synchronizers, edge-armed flags, ir_reg, FIFO pointers and count, cmd_overflow and cmd_err.
REQ-037 SHALL hold cmd_valid = 0 and drive all data outputs to 0 during reset.
REQ-038 SHALL, when reset asserts mid-operation, lose queued entries and not emit any partial command.

Verification
REQ-039 SHALL verify an OCIMEM command: vs_uir pulse with ir_in=0, then vs_udr high with sr[37:36]=01 -> cmd_valid on the 3rd edge with target=0, op=1, take=1, jdo=sr.
REQ-040 SHALL verify the channel-range check with NUM_BRK=3: BREAK with chan=2 -> queued with cmd_chan=2; BREAK with chan=3 -> no entry and cmd_err=1.
REQ-041 SHALL verify overflow and full-FIFO push/pop: 5 udr updates, CMD_DEPTH=4, cmd_ready=0 -> 4 entries and cmd_overflow=1; a full FIFO with a coincident pop and push -> count stays 4 and no overflow.
REQ-042 SHALL verify coincident uir_p and udr_p: old ir_reg=2, ir_in=0 -> entry target=2; the next udr -> target=0.
REQ-043 SHALL verify reset with vs_udr held high: after release no entry appears; vs_udr low then high -> exactly one entry.
REQ-044 SHALL verify reset mid-queue: reset with 3 entries queued -> cmd_valid=0, flags=0, and the next entry pops first.
